// File: rtl/rr_stream_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer family.
package rr_stream_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Index width for a channel count, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or above ptr wins,
// with the search wrapping back to channel 0.
module rr_arbiter
    import rr_stream_pkg::*;
#(
    parameter int  NUM_CH = 4,
    localparam int SELW   = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SELW-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SELW-1:0]   grant_idx,
    output logic              any_grant
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            // Explicit wrap keeps the search legal for non-power-of-2 channel counts.
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant_idx  = SELW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a single registered output stage,
// selecting by round-robin (MODE_RR) or by the sel port (MODE_FIXED).
module rr_stream_mux
    import rr_stream_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  WIDTH  = 8,
    parameter int  MODE   = MODE_RR,
    localparam int SELW   = clog2_min1(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [SELW-1:0]         sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SELW-1:0]         out_ch
);

    // Handshake: a word moves on a rising edge when valid and ready are both high in
    // that cycle; a producer holds valid and data stable until it sees its ready.
    localparam bit FIXED = (MODE == MODE_FIXED);

    logic [SELW-1:0]   ptr;
    logic              load_en;
    logic              accept;
    logic [NUM_CH-1:0] rr_grant;
    logic [SELW-1:0]   rr_idx;
    logic              rr_any;
    logic [NUM_CH-1:0] fx_grant;
    logic              fx_any;
    logic [NUM_CH-1:0] g_onehot;
    logic [SELW-1:0]   g_idx;
    logic              g_any;
    logic [SELW-1:0]   ptr_next;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any_grant (rr_any)
    );

    // Out-of-range sel simply produces no grant.
    always_comb begin
        fx_grant = '0;
        fx_any   = 1'b0;
        if ((int'(sel) < NUM_CH) && in_valid[sel]) begin
            fx_any        = 1'b1;
            fx_grant[sel] = 1'b1;
        end
    end

    assign g_onehot = FIXED ? fx_grant : rr_grant;
    assign g_idx    = FIXED ? sel      : rr_idx;
    assign g_any    = FIXED ? fx_any   : rr_any;

    // No skid buffer: out_ready reaches in_ready combinationally.
    assign load_en  = !out_valid || out_ready;
    assign in_ready = (load_en && !rst) ? g_onehot : '0;
    assign accept   = g_any && load_en && !rst;

    assign ptr_next = (int'(g_idx) == NUM_CH - 1) ? '0 : SELW'(int'(g_idx) + 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (accept) begin
                out_data  <= in_data[int'(g_idx)*WIDTH +: WIDTH];
                out_ch    <= g_idx;
                out_valid <= 1'b1;
                if (!FIXED) ptr <= ptr_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: four instances cover round-robin and fixed
// selection at NUM_CH=4 and the non-power-of-2 case NUM_CH=3.
module tb_rr_stream_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // 4-channel stimulus shared by the round-robin and fixed instances
    logic [31:0] d4    = '0;
    logic [3:0]  v4    = '0;
    logic [1:0]  sel4  = '0;
    logic        ordy4 = 1'b0;
    logic [3:0]  rr4_ready, fx4_ready;
    logic [7:0]  rr4_data, fx4_data;
    logic        rr4_valid, fx4_valid;
    logic [1:0]  rr4_ch, fx4_ch;

    // 3-channel stimulus shared by the round-robin and fixed instances
    logic [23:0] d3    = '0;
    logic [2:0]  v3    = '0;
    logic [1:0]  sel3  = '0;
    logic        ordy3 = 1'b0;
    logic [2:0]  rr3_ready, fx3_ready;
    logic [7:0]  rr3_data, fx3_data;
    logic        rr3_valid, fx3_valid;
    logic [1:0]  rr3_ch, fx3_ch;

    always #5 clk = ~clk;

    rr_stream_mux #(.NUM_CH(4), .WIDTH(8), .MODE(0)) u_rr4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_ready(rr4_ready),
        .sel(sel4), .out_data(rr4_data), .out_valid(rr4_valid), .out_ready(ordy4),
        .out_ch(rr4_ch));

    rr_stream_mux #(.NUM_CH(4), .WIDTH(8), .MODE(1)) u_fx4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_ready(fx4_ready),
        .sel(sel4), .out_data(fx4_data), .out_valid(fx4_valid), .out_ready(ordy4),
        .out_ch(fx4_ch));

    rr_stream_mux #(.NUM_CH(3), .WIDTH(8), .MODE(0)) u_rr3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(rr3_ready),
        .sel(sel3), .out_data(rr3_data), .out_valid(rr3_valid), .out_ready(ordy3),
        .out_ch(rr3_ch));

    rr_stream_mux #(.NUM_CH(3), .WIDTH(8), .MODE(1)) u_fx3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(fx3_ready),
        .sel(sel3), .out_data(fx3_data), .out_valid(fx3_valid), .out_ready(ordy3),
        .out_ch(fx3_ch));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        v4 = '0; v3 = '0; ordy4 = 1'b0; ordy3 = 1'b0; sel4 = '0; sel3 = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        // power-up reset still asserted here
        #2;
        v4 = 4'hF;
        #1;
        checks++;
        if (rr4_valid !== 1'b0 || rr4_data !== 8'h00 || rr4_ch !== 2'd0 || rr4_ready !== 4'h0) begin
            errors++;
            $display("FAIL reset_init: valid=%b data=%h ch=%0d ready=%b, want 0 00 0 0000",
                     rr4_valid, rr4_data, rr4_ch, rr4_ready);
        end
        do_reset();
        // load A5 into the output register, then stall it and bump ptr to 1
        d4 = 32'h000000A5; v4 = 4'b0001; ordy4 = 1'b0;
        tick();
        v4 = '0;
        #1;
        checks++;
        if (rr4_valid !== 1'b1 || rr4_data !== 8'hA5 || rr4_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_preload: valid=%b data=%h ch=%0d, want 1 a5 0",
                     rr4_valid, rr4_data, rr4_ch);
        end
        // asynchronous reset mid-cycle, checked before any clock edge
        v4 = 4'hF;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rr4_valid !== 1'b0 || rr4_data !== 8'h00 || rr4_ch !== 2'd0 || rr4_ready !== 4'h0) begin
            errors++;
            $display("FAIL reset_async: valid=%b data=%h ch=%0d ready=%b, want 0 00 0 0000",
                     rr4_valid, rr4_data, rr4_ch, rr4_ready);
        end
        tick();
        rst = 1'b0;
        d4 = 32'h13121110; ordy4 = 1'b1;
        #1;
        checks++;
        if (rr4_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant_ready: got %b want 0001", rr4_ready);
        end
        tick();
        checks++;
        if (rr4_valid !== 1'b1 || rr4_ch !== 2'd0 || rr4_data !== 8'h10) begin
            errors++;
            $display("FAIL reset_first_grant: valid=%b ch=%0d data=%h, want 1 0 10",
                     rr4_valid, rr4_ch, rr4_data);
        end
    endtask

    task automatic test_rr_full();
        logic [3:0] exp_ready;
        do_reset();
        d4 = 32'h13121110; v4 = 4'hF; ordy4 = 1'b1;
        #1;
        checks++;
        if (rr4_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rr_full_ready0: got %b want 0001", rr4_ready);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_ready = 4'b0001 << ((i + 1) % 4);
            checks++;
            if (rr4_valid !== 1'b1 || rr4_ch !== 2'(i % 4) || rr4_data !== 8'(8'h10 + i % 4)
                || rr4_ready !== exp_ready) begin
                errors++;
                $display("FAIL rr_full[%0d]: valid=%b ch=%0d data=%h ready=%b, want 1 %0d %h %b",
                         i, rr4_valid, rr4_ch, rr4_data, rr4_ready, i % 4, 8'h10 + i % 4, exp_ready);
            end
        end
    endtask

    task automatic test_rr_sparse();
        logic [1:0] exp_ch [3];
        logic [3:0] exp_ready [3];
        exp_ch = '{2'd3, 2'd1, 2'd3};
        exp_ready = '{4'b0010, 4'b1000, 4'b0010};
        do_reset();
        d4 = 32'h23222120; ordy4 = 1'b1;
        // accept channel 1 alone so ptr moves to 2
        v4 = 4'b0010;
        tick();
        v4 = 4'b1010;
        #1;
        checks++;
        if (rr4_ch !== 2'd1 || rr4_ready !== 4'b1000) begin
            errors++;
            $display("FAIL rr_sparse_setup: ch=%0d ready=%b, want 1 1000", rr4_ch, rr4_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rr4_valid !== 1'b1 || rr4_ch !== exp_ch[i] || rr4_data !== {6'h08, exp_ch[i]}
                || rr4_ready !== exp_ready[i]) begin
                errors++;
                $display("FAIL rr_sparse[%0d]: valid=%b ch=%0d data=%h ready=%b, want 1 %0d %h %b",
                         i, rr4_valid, rr4_ch, rr4_data, rr4_ready, exp_ch[i], {6'h08, exp_ch[i]},
                         exp_ready[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        d4 = 32'h33323130; v4 = 4'hF; ordy4 = 1'b1;
        tick();
        ordy4 = 1'b0;
        #1;
        checks++;
        if (rr4_ready !== 4'h0) begin
            errors++;
            $display("FAIL bp_ready_drop: got %b want 0000", rr4_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rr4_valid !== 1'b1 || rr4_data !== 8'h30 || rr4_ch !== 2'd0 || rr4_ready !== 4'h0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h ch=%0d ready=%b, want 1 30 0 0000",
                         i, rr4_valid, rr4_data, rr4_ch, rr4_ready);
            end
        end
        ordy4 = 1'b1;
        #1;
        checks++;
        if (rr4_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 0010", rr4_ready);
        end
        tick();
        checks++;
        if (rr4_valid !== 1'b1 || rr4_data !== 8'h31 || rr4_ch !== 2'd1) begin
            errors++;
            $display("FAIL bp_no_bubble: valid=%b data=%h ch=%0d, want 1 31 1",
                     rr4_valid, rr4_data, rr4_ch);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        d4 = 32'h43424140; v4 = 4'hF; sel4 = 2'd2; ordy4 = 1'b1;
        #1;
        checks++;
        if (fx4_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_ready_sel2: got %b want 0100", fx4_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (fx4_valid !== 1'b1 || fx4_ch !== 2'd2 || fx4_data !== 8'h42) begin
                errors++;
                $display("FAIL fixed_sel2[%0d]: valid=%b ch=%0d data=%h, want 1 2 42",
                         i, fx4_valid, fx4_ch, fx4_data);
            end
        end
        sel4 = 2'd1;
        #1;
        checks++;
        if (fx4_ready !== 4'b0010) begin
            errors++;
            $display("FAIL fixed_ready_sel1: got %b want 0010", fx4_ready);
        end
        tick();
        checks++;
        if (fx4_valid !== 1'b1 || fx4_ch !== 2'd1 || fx4_data !== 8'h41) begin
            errors++;
            $display("FAIL fixed_sel1: valid=%b ch=%0d data=%h, want 1 1 41",
                     fx4_valid, fx4_ch, fx4_data);
        end
        // selected channel not valid: no grant, output drains
        v4 = 4'b1101;
        #1;
        checks++;
        if (fx4_ready !== 4'h0) begin
            errors++;
            $display("FAIL fixed_idle_ready: got %b want 0000", fx4_ready);
        end
        tick();
        checks++;
        if (fx4_valid !== 1'b0 || fx4_data !== 8'h41 || fx4_ch !== 2'd1) begin
            errors++;
            $display("FAIL fixed_idle_drain: valid=%b data=%h ch=%0d, want 0 41 1",
                     fx4_valid, fx4_data, fx4_ch);
        end
    endtask

    task automatic test_np2_wrap();
        do_reset();
        d3 = 24'h525150; v3 = 3'b111; ordy3 = 1'b1; sel3 = 2'd0;
        tick();
        checks++;
        if (fx3_valid !== 1'b1 || fx3_ch !== 2'd0 || fx3_data !== 8'h50) begin
            errors++;
            $display("FAIL np2_fixed_load: valid=%b ch=%0d data=%h, want 1 0 50",
                     fx3_valid, fx3_ch, fx3_data);
        end
        sel3 = 2'd3;
        #1;
        checks++;
        if (fx3_ready !== 3'b000) begin
            errors++;
            $display("FAIL np2_sel3_ready: got %b want 000", fx3_ready);
        end
        tick();
        checks++;
        if (fx3_valid !== 1'b0) begin
            errors++;
            $display("FAIL np2_sel3_drain: valid=%b want 0", fx3_valid);
        end
        do_reset();
        d3 = 24'h525150; v3 = 3'b111; ordy3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rr3_valid !== 1'b1 || rr3_ch !== 2'(i % 3) || rr3_data !== 8'(8'h50 + i % 3)) begin
                errors++;
                $display("FAIL np2_rr[%0d]: valid=%b ch=%0d data=%h, want 1 %0d %h",
                         i, rr3_valid, rr3_ch, rr3_data, i % 3, 8'h50 + i % 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_full();
        test_rr_sparse();
        test_backpressure();
        test_fixed();
        test_np2_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel successor to the team's 2:1 combinational mux.
- Selects one of NUM_CH valid/ready input streams and drives it into a single registered output stream.
- Arbitration is round-robin, or fixed through a sel port, chosen by MODE.
- Sits between multiple producers and one shared consumer; adds exactly one cycle of latency at full throughput.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel in bits.
- MODE, 0, 0 = round-robin arbitration, 1 = fixed selection via sel.
- SELW, $clog2(NUM_CH) (minimum 1), width of sel and out_ch. This is a derived localparam, not user-set.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_CH  per-channel valid
- in_ready  output  NUM_CH  per-channel ready; combinational, at most one bit high (one-hot)
- sel  input  SELW  channel select; used only when MODE=1
- out_data  output  WIDTH  registered output data
- out_valid  output  1  registered output valid
- out_ready  input  1  downstream ready
- out_ch  output  SELW  index of the channel that supplied out_data

Behaviour:
- Reset (asynchronous, rst=1):
  - out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
  - in_ready is all-zero while rst=1.
  - A word held in the output register when reset asserts is discarded.
- Load enable:
  - load_en = !out_valid || out_ready.
  - This is a combinational path from out_ready to in_ready, by design. The block has no skid buffer.
- Grant g, computed combinationally:
  - MODE=0: the first i with in_valid[i]=1, searching from ptr upward and wrapping modulo NUM_CH.
  - MODE=1: g=sel if sel<NUM_CH and in_valid[sel]=1; otherwise no grant. Out-of-range sel never grants and never errors.
- in_ready[g]=load_en when a grant exists; every other bit of in_ready is 0.
- Accept occurs when in_valid[g] && in_ready[g]. On the next rising edge:
  - out_data <= channel g data, out_ch <= g, out_valid <= 1.
  - MODE=0 only: ptr <= (g+1) mod NUM_CH, with explicit wrap when NUM_CH is not a power of 2.
- No accept and out_ready=1: out_valid <= 0. out_data and out_ch hold their stale values.
- out_valid=1 and out_ready=0: the output register holds; all in_ready bits are 0.
- Simultaneous drain and load (out_valid=1, out_ready=1, accept) gives back-to-back words with no bubble. Throughput is 1 word per cycle.
- Latency: an accepted input appears on out_data exactly 1 cycle after the accept edge.
- ptr changes only on an accept. ptr is unused in MODE=1.
- Fairness (MODE=0): with all channels requesting continuously, grants rotate 0,1,..,NUM_CH-1,0. No channel waits more than NUM_CH-1 accepts.
- A producer may hold valid without being granted. The block never drops a valid input word that was not accepted.

Decomposition:
- Package rr_stream_pkg:
  - MODE_RR=0 and MODE_FIXED=1 constants.
  - A clog2-with-minimum-1 function for SELW.
- Sub-module rr_arbiter (parameter NUM_CH):
  - Inputs: req[NUM_CH], ptr[SELW].
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; reused by future arbitration blocks.
- The top level holds the ptr register, the output register, load_en logic and the MODE=1 select path.

Test Plan:
- Reset mid-transfer: assert rst while out_valid=1 with out_data=8'hA5 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately and before any clock edge. After release, the first grant starts from channel 0.
- RR full load: NUM_CH=4, all in_valid=1, out_ready=1 for 8 cycles, channel i data=8'h10+i -> out_ch sequence 0,1,2,3,0,1,2,3; out_data 10,11,12,13,10,...; out_valid continuously high after the first cycle.
- RR sparse request: only channels 1 and 3 valid, ptr=2 -> grant 3, then 1, then 3. in_ready[0] and in_ready[2] stay 0 throughout.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data is stable and in_ready is all-zero. When out_ready returns to 1, the next word loads in the same cycle with no bubble.
- Fixed mode: MODE=1, sel=2, channels 0..3 all valid -> only channel 2 is ever accepted and out_ch=2. sel changed to 1 -> the next word comes from channel 1.
- Non-power-of-2 wrap: NUM_CH=3, MODE=1, sel=3 -> no grant and out_valid falls to 0. MODE=0 with all channels valid -> ptr wraps 2->0, giving out_ch 0,1,2,0.
